// File: rtl/mux_arb_pkg.sv
// Shared arbitration helpers: mode encodings and a round-robin pick function.
// Latency: not applicable (constants and a pure function).
// Backpressure: not applicable.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest supported request vector and the matching pointer width.
    localparam int MAX_N = 16;
    localparam int PTR_W = 4;

    // One-hot pick of the first set bit at or above ptr, wrapping at MAX_N.
    // Callers with fewer channels zero-pad valid; the padding bits are never
    // set, so wrapping at MAX_N behaves exactly like wrapping at the real
    // channel count as long as ptr stays below it. ptr=0 gives lowest-index
    // priority.
    function automatic logic [MAX_N-1:0] rr_pick(
        input logic [MAX_N-1:0] valid,
        input logic [PTR_W-1:0] ptr
    );
        logic [MAX_N-1:0] gnt;
        logic             found;
        logic [PTR_W-1:0] idx;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_N; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && valid[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mux_arb_grant.sv
// Combinational one-hot grant: fixed lowest-index priority or round-robin from ptr.
// Latency: zero cycles, purely combinational.
// Backpressure: none here; the caller qualifies the grant with its own load condition.
module mux_arb_grant
    import mux_arb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [N_IN-1:0]  grant,
    output logic             grant_vld
);

    logic [MAX_N-1:0] req_pad;
    logic [MAX_N-1:0] grant_pad;
    logic [PTR_W-1:0] ptr_pad;

    // Fixed priority is round-robin starting from channel 0.
    assign req_pad   = MAX_N'(req);
    assign ptr_pad   = (rr_mode == MODE_FIXED) ? '0 : PTR_W'(ptr);
    assign grant_pad = rr_pick(req_pad, ptr_pad);
    assign grant     = grant_pad[N_IN-1:0];
    assign grant_vld = |grant_pad;

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 arbitrating registered mux (MUX_ARB_LOCK_EN adds in_last/out_last packet locking).
// Latency: one cycle from accepted input beat to out_valid.
// Backpressure: out_valid & !out_ready stalls all inputs; drain and reload in one cycle gives full rate.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int WIDTH = 32,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_IN-1:0]       in_last,
`endif
    output logic [N_IN-1:0]       in_ready,
    input  logic                  rr_mode,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
`ifdef MUX_ARB_LOCK_EN
    output logic                  out_last,
`endif
    input  logic                  out_ready
);

    logic [N_IN-1:0]  arb_grant;
    logic             arb_vld;
    logic [N_IN-1:0]  grant;
    logic             grant_vld;
    logic             load;
    logic             xfer;
    logic             rr_adv;
    logic [SEL_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_data;
    logic             pick_last;
    logic [SEL_W-1:0] next_ptr;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
`ifdef MUX_ARB_LOCK_EN
    logic             out_last_q,  out_last_d;
    logic             lock_q,      lock_d;
    logic [SEL_W-1:0] lock_ch_q,   lock_ch_d;
`endif

    mux_arb_grant #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_grant (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .rr_mode   (rr_mode),
        .grant     (arb_grant),
        .grant_vld (arb_vld)
    );

`ifdef MUX_ARB_LOCK_EN
    // While a packet is open only its owner may be granted, even if it idles.
    always_comb begin
        grant     = arb_grant;
        grant_vld = arb_vld;
        if (lock_q) begin
            grant            = '0;
            grant[lock_ch_q] = in_valid[lock_ch_q];
            grant_vld        = in_valid[lock_ch_q];
        end
    end
`else
    assign grant     = arb_grant;
    assign grant_vld = arb_vld;
`endif

    // The output slot is free when empty or being drained this cycle.
    // in_ready is forced low during reset even though the slot reads empty.
    assign load     = !out_valid_q | out_ready;
    assign xfer     = grant_vld & load;
    assign in_ready = grant & {N_IN{load & rst_n}};

    // Encode the one-hot grant into an index and steer the granted data.
    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        pick_last = 1'b1;
        for (int i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                pick_idx  = SEL_W'(i);
                pick_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_LOCK_EN
                pick_last = in_last[i];
`endif
            end
        end
    end

    // Pointer moves just past the winner, wrapping from the top channel to 0.
    assign next_ptr = (pick_idx == SEL_W'(N_IN - 1)) ? '0 : pick_idx + SEL_W'(1);
    // Without locking every beat counts as a packet end.
    assign rr_adv   = (rr_mode == MODE_RR) & pick_last;

    // Next-state: load on transfer, clear valid on a plain drain, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef MUX_ARB_LOCK_EN
        out_last_d  = out_last_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = pick_data;
            out_sel_d   = pick_idx;
            if (rr_adv) begin
                rr_ptr_d = next_ptr;
            end
`ifdef MUX_ARB_LOCK_EN
            out_last_d = pick_last;
            lock_d     = !pick_last;
            lock_ch_d  = pick_idx;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending beat and open packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
`ifdef MUX_ARB_LOCK_EN
            out_last_q  <= 1'b0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_ARB_LOCK_EN
            out_last_q  <= out_last_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
`ifdef MUX_ARB_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule
